// File: rtl/decomp_pkg.sv
// Shared types and constants for the decompress sequencer and its pair FIFO.
// A code pair is {in1,in2}; in1 carries the bit value and run length.
package decomp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        DONE_LOW
    } state_t;

    localparam int PAIR_W   = 16;
    localparam int RUN_MSB  = 6;
    localparam int CURSOR_W = 32;

    function automatic logic [CURSOR_W-1:0] run_len(input logic [7:0] code);
        return {{(CURSOR_W-RUN_MSB-1){1'b0}}, code[RUN_MSB:0]};
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of code pairs with an extra pointer MSB for full/empty.
// A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
module pair_fifo
    import decomp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [PAIR_W-1:0] wr_data,
    input  logic              pop,
    output logic [PAIR_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [PAIR_W-1:0] mem [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/decompress_sequencer.sv
// Pairs the compressed byte stream into codes, buffers them, and issues one
// code at a time to the handler while tracking cursor and decompressed bits.
module decompress_sequencer
    import decomp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                start,
    input  logic [CURSOR_W-1:0] base_addr,
    input  logic [CURSOR_W-1:0] total_bits,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          in1,
    output logic [7:0]          in2,
    output logic [CURSOR_W-1:0] byteIndx,
    output logic [2:0]          bitIndx,
    output logic                work,
    output logic                working,
    input  logic                done,
    input  logic [CURSOR_W-1:0] newByteIndx,
    input  logic [2:0]          newBitIndx,
    output logic                busy,
    output logic                finished,
    output logic                overrun,
    output logic                err_timeout
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t              state;
    state_t              next_state;
    logic                phase;
    logic [7:0]          hold_byte;
    logic [CURSOR_W-1:0] bits_done;
    logic [CURSOR_W-1:0] total_q;
    logic [TW-1:0]       timer;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                fifo_push;
    logic [PAIR_W-1:0]   fifo_pair;
    logic                accept_start;
    logic                byte_fire;
    logic                run_nonzero;
    logic                timer_expired;
    logic                job_complete;

    assign accept_start  = start & (state == IDLE);
    assign in_ready      = busy & ~fifo_full;
    assign byte_fire     = in_valid & in_ready;
    assign fifo_push     = byte_fire & phase;
    assign run_nonzero   = (fifo_pair[8+RUN_MSB:8] != '0);
    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign job_complete  = (bits_done >= total_q);

    pair_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (RST),
        .flush  (accept_start),
        .push   (fifo_push),
        .wr_data({hold_byte, in_data}),
        .pop    (fifo_pop),
        .rd_data(fifo_pair),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && total_bits != '0) next_state = FETCH;
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (run_nonzero) next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (done)               next_state = DONE_LOW;
                else if (timer_expired) next_state = IDLE;
            end
            DONE_LOW: begin
                if (!done) next_state = job_complete ? IDLE : FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            phase       <= 1'b0;
            hold_byte   <= '0;
            in1         <= '0;
            in2         <= '0;
            byteIndx    <= '0;
            bitIndx     <= 3'd7;
            work        <= 1'b0;
            working     <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            overrun     <= 1'b0;
            err_timeout <= 1'b0;
            bits_done   <= '0;
            total_q     <= '0;
            timer       <= '0;
        end else begin
            if (accept_start) begin
                phase <= 1'b0;
            end else if (byte_fire) begin
                phase <= ~phase;
                if (!phase) hold_byte <= in_data;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        byteIndx    <= base_addr;
                        bitIndx     <= 3'd7;
                        bits_done   <= '0;
                        total_q     <= total_bits;
                        overrun     <= 1'b0;
                        err_timeout <= 1'b0;
                        // An empty job completes without ever going busy
                        finished    <= (total_bits == '0);
                        busy        <= (total_bits != '0);
                    end
                end
                FETCH: begin
                    if (!fifo_empty && run_nonzero) begin
                        in1 <= fifo_pair[15:8];
                        in2 <= fifo_pair[7:0];
                    end
                end
                ISSUE: begin
                    work    <= 1'b1;
                    working <= 1'b1;
                    timer   <= '0;
                end
                WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (done) begin
                        byteIndx  <= newByteIndx;
                        bitIndx   <= newBitIndx;
                        bits_done <= bits_done + run_len(in1);
                        work      <= 1'b0;
                        working   <= 1'b0;
                    end else if (timer_expired) begin
                        err_timeout <= 1'b1;
                        work        <= 1'b0;
                        working     <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                DONE_LOW: begin
                    if (!done && job_complete) begin
                        finished <= 1'b1;
                        overrun  <= (bits_done > total_q);
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_sequencer.sv
// Directed bench: scoreboard of issued code pairs plus a handler model.
// Cursor and completion expectations are derived from base and run lengths.
module tb_decompress_sequencer;
    import decomp_pkg::*;

    localparam int DEPTH = 2;
    localparam int TMO   = 4096;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] total_bits = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in1, in2;
    logic [31:0] byteIndx;
    logic [2:0]  bitIndx;
    logic        work, working;
    logic        done = 1'b0;
    logic [31:0] newByteIndx = '0;
    logic [2:0]  newBitIndx = '0;
    logic        busy, finished, overrun, err_timeout;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    int          work_count = 0;
    logic        work_q = 1'b0;
    int          handler_delay = 2;
    bit          handler_en = 1'b1;
    int          hcnt = 0;
    bit          stall_seen = 1'b0;
    logic [31:0] pos;
    logic [15:0] exp_pair;
    int          cyc;

    decompress_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .base_addr  (base_addr),
        .total_bits (total_bits),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .byteIndx   (byteIndx),
        .bitIndx    (bitIndx),
        .work       (work),
        .working    (working),
        .done       (done),
        .newByteIndx(newByteIndx),
        .newBitIndx (newBitIndx),
        .busy       (busy),
        .finished   (finished),
        .overrun    (overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_byte(input logic [31:0] b,
                                             input int bits);
        return b + 32'(bits / 8);
    endfunction

    function automatic logic [31:0] exp_bit(input int bits);
        return 32'(7 - (bits % 8));
    endfunction

    // Scoreboard: every rising edge of work must present the next pair
    initial forever begin
        @(negedge clk);
        if (work && !work_q) begin
            work_count++;
            if (exp_q.size() == 0) begin
                chk("issue_unexpected", 32'd1, 32'd0);
            end else begin
                exp_pair = exp_q.pop_front();
                chk("issue_pair", {16'd0, in1, in2}, {16'd0, exp_pair});
            end
        end
        work_q = work;
    end

    // Handler model: advances the cursor by the run length after a delay
    initial forever begin
        @(negedge clk);
        if (RST) begin
            done = 1'b0;
            hcnt = 0;
        end else if (done) begin
            if (!work) done = 1'b0;
        end else if (work && handler_en) begin
            if (hcnt >= handler_delay) begin
                pos = {byteIndx[28:0], 3'b000} + 32'(3'd7 - bitIndx)
                      + 32'(in1[6:0]);
                newByteIndx = pos >> 3;
                newBitIndx  = 3'd7 - pos[2:0];
                done = 1'b1;
                hcnt = 0;
            end else begin
                hcnt++;
            end
        end else begin
            hcnt = 0;
        end
    end

    task automatic start_job(input logic [31:0] b, input logic [31:0] t);
        base_addr  = b;
        total_bits = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 5000) begin
            if (busy) stall_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("send_stuck", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        if (a[6:0] != 7'd0) exp_q.push_back({a, b});
        send_byte(a);
        send_byte(b);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_work(input string tag);
        int n = 0;
        while (!work && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_work"}, 32'(work), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_work", 32'(work), 0);
        chk("rst_working", 32'(working), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, finished, overrun, err_timeout}, 0);
        chk("rst_byte", byteIndx, 0);
        chk("rst_bit", 32'(bitIndx), 7);
        chk("rst_code", {16'd0, in1, in2}, 0);
        RST = 1'b0;
        @(negedge clk);

        work_count = 0;
        start_job(100, 5);
        chk("t1_busy", 32'(busy), 1);
        send_pair(8'h85, 8'h00);
        wait_idle("t1");
        chk("t1_works", work_count, 1);
        chk("t1_byte", byteIndx, 100);
        chk("t1_bit", 32'(bitIndx), 2);
        chk("t1_finished", 32'(finished), 1);
        chk("t1_overrun", 32'(overrun), 0);

        work_count = 0;
        start_job(0, 20);
        chk("t2_finished_clr", 32'(finished), 0);
        send_pair(8'h08, 8'h11);
        send_pair(8'h88, 8'h22);
        send_pair(8'h04, 8'h33);
        wait_idle("t2");
        chk("t2_works", work_count, 3);
        chk("t2_bits_done", dut.bits_done, 20);
        chk("t2_byte", byteIndx, exp_byte(0, 20));
        chk("t2_bit", 32'(bitIndx), exp_bit(20));
        chk("t2_finished", 32'(finished), 1);
        chk("t2_q", exp_q.size(), 0);

        work_count = 0;
        handler_delay = 50;
        stall_seen = 1'b0;
        start_job(32'h200, 21);
        for (int i = 1; i <= 6; i++)
            send_pair(8'(i) | ((i % 2) != 0 ? 8'h80 : 8'h00), 8'(8'hA0 + i));
        wait_idle("t3");
        chk("t3_stall", 32'(stall_seen), 1);
        chk("t3_works", work_count, 6);
        chk("t3_byte", byteIndx, exp_byte(32'h200, 21));
        chk("t3_bit", 32'(bitIndx), exp_bit(21));
        chk("t3_q", exp_q.size(), 0);
        handler_delay = 2;

        work_count = 0;
        start_job(10, 6);
        send_pair(8'h83, 8'h01);
        send_pair(8'h00, 8'h00);
        send_pair(8'h03, 8'h02);
        wait_idle("t4");
        chk("t4_works", work_count, 2);
        chk("t4_finished", 32'(finished), 1);
        chk("t4_overrun", 32'(overrun), 0);
        chk("t4_byte", byteIndx, exp_byte(10, 6));
        chk("t4_bit", 32'(bitIndx), exp_bit(6));

        work_count = 0;
        start_job(0, 5);
        send_pair(8'h83, 8'h00);
        send_pair(8'h03, 8'h00);
        wait_idle("t5");
        chk("t5_works", work_count, 2);
        chk("t5_finished", 32'(finished), 1);
        chk("t5_overrun", 32'(overrun), 1);

        work_count = 0;
        start_job(0, 0);
        chk("t6_finished", 32'(finished), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_overrun", 32'(overrun), 0);
        repeat (5) @(negedge clk);
        chk("t6_works", work_count, 0);

        handler_en = 1'b0;
        start_job(0, 10);
        send_pair(8'h0A, 8'h00);
        wait_work("t7");
        cyc = 0;
        while (!err_timeout && cyc < TMO + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("t7_cycles", cyc, TMO);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_work", 32'(work), 0);
        chk("t7_state", 32'(dut.state), 32'(IDLE));
        chk("t7_finished", 32'(finished), 0);

        start_job(40, 10);
        chk("t8_err_clr", 32'(err_timeout), 0);
        send_pair(8'h0A, 8'h00);
        wait_work("t8");
        start_job(999, 3);
        chk("t8_ign_byte", byteIndx, 40);
        chk("t8_ign_busy", 32'(busy), 1);
        RST = 1'b1;
        #1;
        chk("t8_rst_work", 32'(work), 0);
        chk("t8_rst_busy", 32'(busy), 0);
        chk("t8_rst_byte", byteIndx, 0);
        chk("t8_rst_bit", 32'(bitIndx), 7);
        chk("t8_rst_ready", 32'(in_ready), 0);
        chk("t8_rst_code", {16'd0, in1, in2}, 0);
        @(negedge clk);
        RST = 1'b0;
        handler_en = 1'b1;
        exp_q.delete();
        @(negedge clk);

        work_count = 0;
        start_job(100, 5);
        send_pair(8'h85, 8'h00);
        wait_idle("t9");
        chk("t9_works", work_count, 1);
        chk("t9_byte", byteIndx, 100);
        chk("t9_bit", 32'(bitIndx), 2);
        chk("t9_finished", 32'(finished), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
